// File: rtl/pool2d_engine.sv
// pool2d_engine: buffers one IN_DIM x IN_DIM feature map streamed in raster
// order, then emits one max- or average-pooled value per cycle for each
// non-overlapping POOL x POOL window, with ready/valid on both sides.
module pool2d_engine #(
   parameter int DATA_W = 16,
   parameter int IN_DIM = 6,
   parameter int POOL   = 2,
   parameter int OUT_AW = 4,
   parameter int IDX_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [OUT_AW-1:0] out_addr,
   output logic [IDX_W-1:0]  out_idx,
   output logic              done
);

   localparam int OUT_DIM = IN_DIM / POOL;
   localparam int NPIX    = IN_DIM * IN_DIM;
   localparam int NOUT    = OUT_DIM * OUT_DIM;
   localparam int LOG2P   = $clog2(POOL);
   localparam int SHIFT   = 2 * LOG2P;
   localparam int WIN     = POOL * POOL;
   localparam int SUM_W   = DATA_W + SHIFT;
   localparam int PIX_W   = $clog2(NPIX);
   localparam int RC_W    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

   // The PRIME cycle is the S_POOL state with out_valid_q still low.
   typedef enum logic [1:0] {
      S_LOAD,
      S_POOL,
      S_DONE
   } state_t;

   state_t              state_q;
   logic [PIX_W-1:0]    pix_cnt_q;
   logic                mode_q;
   logic                out_valid_q;
   logic [DATA_W-1:0]   out_data_q;
   logic [OUT_AW-1:0]   out_addr_q;
   logic [IDX_W-1:0]    out_idx_q;
   logic                done_q;
   logic [RC_W-1:0]     row_q;
   logic [RC_W-1:0]     col_q;
   logic [DATA_W-1:0]   buf_q [NPIX];

   // Window to load on the next output edge and its reduction results
   logic [RC_W-1:0]     row_d;
   logic [RC_W-1:0]     col_d;
   logic [PIX_W-1:0]    win_base;
   logic [PIX_W-1:0]    rd_addr;
   logic [DATA_W-1:0]   pix;
   logic [DATA_W-1:0]   best;
   logic [IDX_W-1:0]    best_k;
   logic [SUM_W-1:0]    sum;
   logic [DATA_W-1:0]   win_data_d;
   logic [IDX_W-1:0]    win_idx_d;

   logic                pix_acc;
   logic                last_pix;
   logic                last_win;

   assign in_ready  = (state_q == S_LOAD);
   assign pix_acc   = in_valid && in_ready;
   assign last_pix  = (pix_cnt_q == PIX_W'(NPIX - 1));
   assign last_win  = (out_addr_q == OUT_AW'(NOUT - 1));

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_addr  = out_addr_q;
   assign out_idx   = out_idx_q;
   assign done      = done_q;

   // NOTE: the pixel buffer has no reset; every location is rewritten by the
   // next frame before it is read, so resetting it would only cost logic.
   // Pixel buffer write, one location per accepted input pixel
   always_ff @(posedge clk) begin
      if (pix_acc) begin
         buf_q[pix_cnt_q] <= in_data;
      end
   end

   // Next window coordinates: window 0 during PRIME, raster successor otherwise
   always_comb begin
      row_d = '0;
      col_d = '0;
      if (out_valid_q) begin
         if (col_q == RC_W'(OUT_DIM - 1)) begin
            row_d = row_q + RC_W'(1);
            col_d = '0;
         end else begin
            row_d = row_q;
            col_d = col_q + RC_W'(1);
         end
      end
   end

   // NOTE: blocking assignments in combinational logic let each loop pass see
   // the running max/sum of the previous pass; every variable gets a default
   // first so no latch is inferred.
   // Max (first-seen wins on ties) and floor-average of the next window
   always_comb begin
      win_base = PIX_W'(int'(row_d) * POOL * IN_DIM + int'(col_d) * POOL);
      rd_addr  = '0;
      pix      = '0;
      best     = '0;
      best_k   = '0;
      sum      = '0;
      for (int k = 0; k < WIN; k++) begin
         rd_addr = win_base + PIX_W'((k / POOL) * IN_DIM + (k % POOL));
         pix     = buf_q[rd_addr];
         if (pix > best) begin
            best   = pix;
            best_k = IDX_W'(k);
         end
         sum = sum + SUM_W'(pix);
      end
      win_data_d = mode_q ? DATA_W'(sum >> SHIFT) : best;
      win_idx_d  = mode_q ? '0 : best_k;
   end

   // Control FSM with registered outputs: load frame, prime, stream, done pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_LOAD;
         pix_cnt_q   <= '0;
         mode_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         out_idx_q   <= '0;
         done_q      <= 1'b0;
         row_q       <= '0;
         col_q       <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_LOAD: begin
               if (pix_acc) begin
                  if (last_pix) begin
                     pix_cnt_q <= '0;
                     mode_q    <= mode;
                     state_q   <= S_POOL;
                  end else begin
                     pix_cnt_q <= pix_cnt_q + PIX_W'(1);
                  end
               end
            end
            S_POOL: begin
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= win_data_d;
                  out_idx_q   <= win_idx_d;
                  out_addr_q  <= '0;
                  row_q       <= row_d;
                  col_q       <= col_d;
               end else if (out_ready) begin
                  if (last_win) begin
                     out_valid_q <= 1'b0;
                     done_q      <= 1'b1;
                     state_q     <= S_DONE;
                  end else begin
                     out_data_q  <= win_data_d;
                     out_idx_q   <= win_idx_d;
                     out_addr_q  <= out_addr_q + OUT_AW'(1);
                     row_q       <= row_d;
                     col_q       <= col_d;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_LOAD;
            end
            default: begin
               state_q <= S_LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pool2d_engine.sv
// Scoreboard bench for pool2d_engine: three instances (4x4/2, 6x6/2, 8x8/4)
// share one driver; a monitor pops expected outputs as the selected DUT
// presents them and checks hold-under-backpressure and done pulses.
module tb_pool2d_engine;

   typedef struct {
      logic [15:0] data;
      logic [3:0]  addr;
      logic [3:0]  idx;
   } exp_t;

   localparam int R6_MAX[9]  = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
   localparam int R6_REV[9]  = '{35, 33, 31, 23, 21, 19, 11, 9, 7};
   localparam int R8_MAX[4]  = '{27, 31, 59, 63};
   localparam int R8_AVG[4]  = '{13, 17, 45, 49};

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mode = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [15:0] in_data = '0;
   int          sel = 0;

   logic [15:0] pix [64];
   exp_t        sb_q [$];
   int          n_tests = 0;
   int          n_fail = 0;
   int          done_cnt = 0;

   // Per-instance signals
   logic        ir4, ov4, d4, ir6, ov6, d6, ir8, ov8, d8;
   logic [15:0] od4, od6, od8;
   logic [3:0]  oa4, oa6;
   logic [1:0]  oa8;
   logic [1:0]  oi4, oi6;
   logic [3:0]  oi8;

   // Selected-instance view
   logic        in_ready_m, out_valid_m, done_m;
   logic [15:0] out_data_m;
   logic [3:0]  out_addr_m, out_idx_m;

   always #5 clk = ~clk;

   pool2d_engine #(.DATA_W(16), .IN_DIM(4), .POOL(2), .OUT_AW(4), .IDX_W(2)) u4 (
      .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid && sel == 0), .in_ready(ir4),
      .in_data(in_data), .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
      .out_addr(oa4), .out_idx(oi4), .done(d4));

   pool2d_engine #(.DATA_W(16), .IN_DIM(6), .POOL(2), .OUT_AW(4), .IDX_W(2)) u6 (
      .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid && sel == 1), .in_ready(ir6),
      .in_data(in_data), .out_valid(ov6), .out_ready(out_ready), .out_data(od6),
      .out_addr(oa6), .out_idx(oi6), .done(d6));

   pool2d_engine #(.DATA_W(16), .IN_DIM(8), .POOL(4), .OUT_AW(2), .IDX_W(4)) u8 (
      .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid && sel == 2), .in_ready(ir8),
      .in_data(in_data), .out_valid(ov8), .out_ready(out_ready), .out_data(od8),
      .out_addr(oa8), .out_idx(oi8), .done(d8));

   always_comb begin
      in_ready_m  = ir6;
      out_valid_m = ov6;
      done_m      = d6;
      out_data_m  = od6;
      out_addr_m  = oa6;
      out_idx_m   = {2'b00, oi6};
      case (sel)
         0: begin
            in_ready_m = ir4; out_valid_m = ov4; done_m = d4;
            out_data_m = od4; out_addr_m = oa4; out_idx_m = {2'b00, oi4};
         end
         2: begin
            in_ready_m = ir8; out_valid_m = ov8; done_m = d8;
            out_data_m = od8; out_addr_m = {2'b00, oa8}; out_idx_m = oi8;
         end
         default: ;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input int d, input int a, input int i);
      exp_t e;
      e.data = 16'(d);
      e.addr = 4'(a);
      e.idx  = 4'(i);
      sb_q.push_back(e);
   endtask

   // Monitor: samples on the falling edge, away from the DUT's active edge
   initial begin
      logic        stalled;
      logic [15:0] pd;
      logic [3:0]  pa, pi;
      exp_t        e;
      stalled = 1'b0;
      pd = '0; pa = '0; pi = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stalled = 1'b0;
            continue;
         end
         if (done_m) done_cnt++;
         if (stalled) begin
            check("held_valid", 32'(out_valid_m), 32'd1);
            check("held_data", 32'(out_data_m), 32'(pd));
            check("held_addr", 32'(out_addr_m), 32'(pa));
            check("held_idx", 32'(out_idx_m), 32'(pi));
         end
         if (out_valid_m) begin
            check("in_ready_low_in_pool", 32'(in_ready_m), 32'd0);
            if (out_ready) begin
               if (sb_q.size() == 0) begin
                  check("unexpected_output", 32'(out_valid_m), 32'd0);
               end else begin
                  e = sb_q.pop_front();
                  check("out_data", 32'(out_data_m), 32'(e.data));
                  check("out_addr", 32'(out_addr_m), 32'(e.addr));
                  check("out_idx", 32'(out_idx_m), 32'(e.idx));
               end
            end
            stalled = !out_ready;
            pd = out_data_m; pa = out_addr_m; pi = out_idx_m;
         end else begin
            stalled = 1'b0;
         end
      end
   end

   // Streams pix[0..n-1] into instance s; returns at (last accept edge)+1
   task automatic send_frame(input int s, input logic m, input int n);
      int t;
      sel  = s;
      mode = m;
      for (int i = 0; i < n; i++) begin
         in_data  = pix[i];
         in_valid = 1'b1;
         t = 0;
         while (!in_ready_m && t < 100) begin
            @(posedge clk); #1;
            t++;
         end
         if (!in_ready_m) begin
            check("in_ready_timeout", 32'(in_ready_m), 32'd1);
            break;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   // Drains the scoreboard (optionally with backpressure) and checks done
   task automatic finish_frame(input bit bp);
      int i;
      int d0;
      d0 = done_cnt;
      i  = 0;
      while (sb_q.size() != 0 && i < 400) begin
         if (!bp || i < 4) out_ready = (i == 1 || i == 2) && bp ? 1'b0 : 1'b1;
         else              out_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         i++;
      end
      out_ready = 1'b1;
      check("frame_drained", 32'(sb_q.size()), 32'd0);
      repeat (3) begin @(posedge clk); #1; end
      check("done_pulses", 32'(done_cnt - d0), 32'd1);
      check("in_ready_after_done", 32'(in_ready_m), 32'd1);
      check("out_valid_after_done", 32'(out_valid_m), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int t;

      // Reset values on every instance
      #2 rst = 1'b1;
      #2;
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check("rst_in_ready", 32'(in_ready_m), 32'd1);
         check("rst_out_valid", 32'(out_valid_m), 32'd0);
         check("rst_out_data", 32'(out_data_m), 32'd0);
         check("rst_out_addr", 32'(out_addr_m), 32'd0);
         check("rst_out_idx", 32'(out_idx_m), 32'd0);
         check("rst_done", 32'(done_m), 32'd0);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // 4x4 ramp, max mode, with latency check
      for (int i = 0; i < 16; i++) pix[i] = 16'(i);
      push(5, 0, 3); push(7, 1, 3); push(13, 2, 3); push(15, 3, 3);
      send_frame(0, 1'b0, 16);
      check("prime_no_valid", 32'(out_valid_m), 32'd0);
      @(posedge clk); #1;
      check("valid_after_prime", 32'(out_valid_m), 32'd1);
      check("first_addr", 32'(out_addr_m), 32'd0);
      finish_frame(1'b0);

      // 4x4 average; mode flipped during POOL must not matter
      for (int i = 0; i < 16; i++) pix[i] = 16'd8;
      pix[0] = 16'd1; pix[1] = 16'd2; pix[4] = 16'd3; pix[5] = 16'd5;
      push(2, 0, 0); push(8, 1, 0); push(8, 2, 0); push(8, 3, 0);
      send_frame(0, 1'b1, 16);
      mode = 1'b0;
      finish_frame(1'b0);

      // 4x4 ties and unsigned compare
      pix[0]  = 16'hFFFF; pix[1]  = 16'h0001; pix[4]  = 16'hFFFF; pix[5]  = 16'h8000;
      pix[2]  = 16'd7;    pix[3]  = 16'd7;    pix[6]  = 16'd7;    pix[7]  = 16'd7;
      pix[8]  = 16'd3;    pix[9]  = 16'd9;    pix[12] = 16'd9;    pix[13] = 16'd1;
      pix[10] = 16'd0;    pix[11] = 16'd0;    pix[14] = 16'd0;    pix[15] = 16'h8000;
      push(16'hFFFF, 0, 0); push(7, 1, 0); push(9, 2, 1); push(16'h8000, 3, 3);
      send_frame(0, 1'b0, 16);
      finish_frame(1'b0);

      // 6x6 ramp, max mode, under backpressure
      for (int i = 0; i < 36; i++) pix[i] = 16'(i);
      for (int i = 0; i < 9; i++) push(R6_MAX[i], i, 3);
      send_frame(1, 1'b0, 36);
      finish_frame(1'b1);

      // 6x6 reset after 10 pixels, then a full descending frame
      for (int i = 0; i < 10; i++) pix[i] = 16'hFFFF;
      send_frame(1, 1'b0, 10);
      rst = 1'b1;
      #1;
      check("midload_rst_in_ready", 32'(in_ready_m), 32'd1);
      check("midload_rst_out_valid", 32'(out_valid_m), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 36; i++) pix[i] = 16'(35 - i);
      for (int i = 0; i < 9; i++) push(R6_REV[i], i, 0);
      send_frame(1, 1'b0, 36);
      finish_frame(1'b0);

      // 6x6 reset while presenting addr 4
      for (int i = 0; i < 36; i++) pix[i] = 16'(i);
      for (int i = 0; i < 9; i++) push(R6_MAX[i], i, 3);
      send_frame(1, 1'b0, 36);
      t = 0;
      while (!(out_valid_m && out_addr_m == 4'd4) && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      check("reached_addr4", 32'(out_addr_m), 32'd4);
      rst = 1'b1;
      #1;
      check("midout_rst_out_valid", 32'(out_valid_m), 32'd0);
      check("midout_rst_in_ready", 32'(in_ready_m), 32'd1);
      check("midout_rst_out_addr", 32'(out_addr_m), 32'd0);
      sb_q.delete();
      d0 = done_cnt;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      check("midout_rst_no_done", 32'(done_cnt - d0), 32'd0);

      // 8x8 ramp, POOL=4, max then average
      for (int i = 0; i < 64; i++) pix[i] = 16'(i);
      for (int i = 0; i < 4; i++) push(R8_MAX[i], i, 15);
      send_frame(2, 1'b0, 64);
      finish_frame(1'b0);
      for (int i = 0; i < 4; i++) push(R8_AVG[i], i, 0);
      send_frame(2, 1'b1, 64);
      finish_frame(1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
